anton_neopixel_stream: RTL and testbench
========================================

# anton_neopixel_stream

Serializer stage directly downstream of the NeoPixel register file. It walks the byte buffer held by the register file, encodes every bit as a WS2812 high/low pulse on a single data pin, then drives the latch (reset) low period. At the end of that period it raises `stream_sync_of`, which the register file uses to clear or keep `reg_ctrl_run` according to `reg_ctrl_loop`.

## Interface
- `BUFFER_END`, `` `BUFFER_END_DEFAULT ``: index of the last buffer byte. `BUFFER_BITS = CLOG2(BUFFER_END+1)`.
- `T0H`, 8: high cycles for a 0 bit.
- `T1H`, 16: high cycles for a 1 bit.
- `TBIT`, 25: total cycles per bit slot. Requires `T0H < T1H < TBIT`.
- `RESET_CYCLES`, 1000: low cycles in the latch period.
- `busClk`  in  1  single clock for all logic.
- `busReset`  in  1  reset, asynchronous, active-high.
- `pixelIndex`  out  BUFFER_BITS  byte address into the register-file buffer.
- `pixelByte`  in  8  buffer byte at `pixelIndex`. Driven combinationally by the outside mux, valid in the same cycle.
- `reg_max`  in  13  last byte index used when limit is on.
- `reg_ctrl_limit`  in  1  use `reg_max` instead of `BUFFER_END`.
- `reg_ctrl_run`  in  1  start request.
- `reg_ctrl_32bit`  in  1  buffer holds 4 bytes per pixel; the 4th byte is padding.
- `neoData`  out  1  serial data to the LEDs.
- `state`  out  1  busy (1 in BIT or LATCH).
- `stream_sync_of`  out  1  one-cycle pulse at the end of a frame.

## Operation
- FSM states: IDLE, BIT, LATCH. All registered.
- Reset values: FSM = IDLE, `neoData`=0, `state`=0, `stream_sync_of`=0, `pixelIndex`=0. All counters are 0.
- **IDLE**
  - `neoData`=0.
  - If `reg_ctrl_run`=1, move to BIT with `pixelIndex`=0, bitCnt=7, cycCnt=0.
- **Bit encoding**
  - Bit `b` = `pixelByte[bitCnt]`, sent MSB first.
  - `neoData`=1 while cycCnt < (b ? `T1H` : `T0H`), else 0.
  - cycCnt counts 0..`TBIT`-1.
- **Bit and byte advance**
  - At cycCnt=`TBIT`-1: cycCnt wraps to 0 and bitCnt decrements.
  - At bitCnt=0, advance to the next byte.
  - In 32-bit mode, skip any index whose `[1:0]`=3 (padding byte).
- **End index**
  - lastIdx = `reg_ctrl_limit` ? min(`reg_max`, `BUFFER_END`) : `BUFFER_END`.
  - `reg_max` values above `BUFFER_END` are clamped.
  - After the last bit of lastIdx, go to LATCH. A 32-bit-mode lastIdx that is a padding byte ends after the preceding byte.
- **LATCH**
  - `neoData`=0 for `RESET_CYCLES` cycles.
  - On the final cycle, pulse `stream_sync_of`=1 and return to IDLE.
  - If `reg_ctrl_run` is still high in IDLE (loop mode), the next frame starts the following cycle.
- **Control changes during a frame**
  - `reg_ctrl_run` falling mid-frame does not abort; the frame and latch complete.
  - `reg_ctrl_limit`, `reg_ctrl_32bit` and `reg_max` are sampled into shadow registers on the IDLE→BIT transition. They are constant for the rest of the frame.
- **Buffer writes**
  - Bytes are read live: a bus write to a byte not yet reached is sent with the new value.
  - Writes to an already-sent byte take effect next frame.
- **Reset mid-frame:** immediate IDLE and `neoData`=0, with no `stream_sync_of`.

## Timing
- **Frame start:** run seen high in IDLE at edge N → first `neoData` rising at edge N+1.
- **Bit slot:** exactly `TBIT` cycles. High time is exactly `T0H` or `T1H` cycles.
- **Byte count:** packed mode sends lastIdx+1 bytes. In 32-bit mode, padding bytes are skipped with no gap cycles.
- **Frame length:** 8·`TBIT`·(bytes sent) + `RESET_CYCLES` cycles. `stream_sync_of` is high in the last of these.
- **Back-to-back frames:** minimum 1 IDLE cycle between `stream_sync_of` and the next frame's first high.
- **`pixelIndex`:** changes only on byte-advance edges and is stable across the whole byte.

## Configuration
- `ANTON_NEOPIXEL_32BIT_EN` defined: `reg_ctrl_32bit` is honoured and padding bytes are skipped.
- Undefined:
  - `reg_ctrl_32bit` is ignored and the skip logic is not synthesized.
  - Every byte up to lastIdx is sent.

## Test plan
- **Single byte:** `BUFFER_END`=3, limit=1, `reg_max`=0, `pixelByte[0]`=0xA5, run pulse → 8 slots with high widths 16,8,16,8,8,16,8,16. Then 1000 low cycles, then one `stream_sync_of` pulse; `state`=1 throughout, 0 afterwards.
- **Full buffer, no limit:** limit=0, `BUFFER_END`=7 → 64 bit slots, then the latch. Total = 64·25+1000 = 2600 cycles up to and including `stream_sync_of`.
- **32-bit skip:** 32-bit=1, limit=1, `reg_max`=7 → `pixelIndex` sequence 0,1,2,4,5,6 and 48 slots total. With the macro undefined, the same stimulus gives 0..7 and 64 slots.
- **Loop:** run held high → second frame's first `neoData` rising exactly 2 cycles after the `stream_sync_of` pulse. Run dropped mid-frame → the frame completes and FSM stays in IDLE.
- **Reset mid-frame:** assert `busReset` during byte 2, bit 3 → `neoData`=0, `state`=0, `pixelIndex`=0 with no clock edge, and no `stream_sync_of`.
- **Clamp and shadow:** `reg_max`=8191 with `BUFFER_END`=7 → 8 bytes sent. Changing `reg_max` mid-frame does not alter the current frame length.

Source files
------------

// File: rtl/anton_neopixel_stream.sv
// -----------------------------------------------------------------------------
// anton_neopixel_stream
//
// WS2812 serializer sitting behind the NeoPixel register file. Walks the byte
// buffer (pixelIndex -> pixelByte, read live), sends each bit MSB first as a
// high/low pulse inside a TBIT-cycle slot, then holds the line low for
// RESET_CYCLES and pulses stream_sync_of on the last latch cycle.
//
// Optional feature macro: ANTON_NEOPIXEL_32BIT_EN
//   defined   - reg_ctrl_32bit honoured, every index with [1:0]==3 is skipped
//   undefined - reg_ctrl_32bit ignored, every byte up to the end index is sent
//
// Ports
//   busClk          clock for all logic
//   busReset        asynchronous active-high reset
//   pixelIndex      byte address into the register-file buffer
//   pixelByte       buffer byte at pixelIndex, valid the same cycle
//   reg_max         last byte index when reg_ctrl_limit is set (clamped)
//   reg_ctrl_limit  use reg_max instead of BUFFER_END
//   reg_ctrl_run    start request (level)
//   reg_ctrl_32bit  4 bytes per pixel, 4th byte is padding
//   neoData         serial LED data (registered)
//   state           busy flag, high while a frame or its latch is in flight
//   stream_sync_of  one-cycle pulse on the final latch cycle
// -----------------------------------------------------------------------------
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 7
`endif

module anton_neopixel_stream #(
  parameter int unsigned BUFFER_END   = `BUFFER_END_DEFAULT,
  parameter int unsigned T0H          = 8,
  parameter int unsigned T1H          = 16,
  parameter int unsigned TBIT         = 25,
  parameter int unsigned RESET_CYCLES = 1000,
  localparam int unsigned BUFFER_BITS = (BUFFER_END == 0) ? 1 : $clog2(BUFFER_END + 1)
) (
  input  logic                   busClk,
  input  logic                   busReset,
  output logic [BUFFER_BITS-1:0] pixelIndex,
  input  logic [7:0]             pixelByte,
  input  logic [12:0]            reg_max,
  input  logic                   reg_ctrl_limit,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_32bit,
  output logic                   neoData,
  output logic                   state,
  output logic                   stream_sync_of
);

  localparam int unsigned CYC_W = (TBIT < 2) ? 1 : $clog2(TBIT);
  localparam int unsigned LAT_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBit   = 2'd1,
    StLatch = 2'd2
  } fsm_e;

  fsm_e                   fsm_q, fsm_d;
  logic [BUFFER_BITS-1:0] pixel_idx_q, pixel_idx_d;
  logic [BUFFER_BITS-1:0] last_q, last_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [CYC_W-1:0]       cyc_cnt_q, cyc_cnt_d;
  logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
  logic                   neo_q, neo_d;
  logic                   busy_q, busy_d;
  logic                   sync_q, sync_d;
`ifdef ANTON_NEOPIXEL_32BIT_EN
  logic                   mode32_q, mode32_d;
`else
  logic                   unused_32bit;
  assign unused_32bit = reg_ctrl_32bit;
`endif

  logic [31:0] last_full;
  logic [31:0] idx_next_full;
  logic [31:0] high_cycles;

  // End index for the frame about to start; snapshotted into last_q so later
  // register writes cannot change the current frame length.
  always_comb begin
    if (reg_ctrl_limit && (32'(reg_max) < BUFFER_END)) begin
      last_full = 32'(reg_max);
    end else begin
      last_full = BUFFER_END;
    end
`ifdef ANTON_NEOPIXEL_32BIT_EN
    // A padding byte as the end index means the frame stops one byte earlier.
    if (reg_ctrl_32bit && (last_full[1:0] == 2'b11)) begin
      last_full = last_full - 32'd1;
    end
`endif
  end

  // Next byte address, hopping over padding bytes in 32-bit mode.
  always_comb begin
    idx_next_full = 32'(pixel_idx_q) + 32'd1;
`ifdef ANTON_NEOPIXEL_32BIT_EN
    if (mode32_q && (idx_next_full[1:0] == 2'b11)) begin
      idx_next_full = idx_next_full + 32'd1;
    end
`endif
  end

  assign high_cycles = pixelByte[bit_cnt_q] ? T1H : T0H;

  always_comb begin
    fsm_d       = fsm_q;
    pixel_idx_d = pixel_idx_q;
    last_d      = last_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    neo_d       = 1'b0;
    sync_d      = 1'b0;
    busy_d      = (fsm_q != StIdle);
`ifdef ANTON_NEOPIXEL_32BIT_EN
    mode32_d    = mode32_q;
`endif

    case (fsm_q)
      StIdle: begin
        if (reg_ctrl_run) begin
          fsm_d       = StBit;
          pixel_idx_d = '0;
          bit_cnt_d   = 3'd7;
          cyc_cnt_d   = '0;
          last_d      = BUFFER_BITS'(last_full);
`ifdef ANTON_NEOPIXEL_32BIT_EN
          mode32_d    = reg_ctrl_32bit;
`endif
        end
      end

      StBit: begin
        neo_d = (32'(cyc_cnt_q) < high_cycles);
        if (cyc_cnt_q == CYC_W'(TBIT - 1)) begin
          cyc_cnt_d = '0;
          // Wraps 0 -> 7, which is exactly the start of the next byte.
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            if (pixel_idx_q == last_q) begin
              fsm_d     = StLatch;
              lat_cnt_d = '0;
            end else begin
              pixel_idx_d = BUFFER_BITS'(idx_next_full);
            end
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end

      StLatch: begin
        if (lat_cnt_q == LAT_W'(RESET_CYCLES - 1)) begin
          sync_d = 1'b1;
          fsm_d  = StIdle;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end

      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      fsm_q       <= StIdle;
      pixel_idx_q <= '0;
      last_q      <= '0;
      bit_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      neo_q       <= 1'b0;
      busy_q      <= 1'b0;
      sync_q      <= 1'b0;
`ifdef ANTON_NEOPIXEL_32BIT_EN
      mode32_q    <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      pixel_idx_q <= pixel_idx_d;
      last_q      <= last_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      neo_q       <= neo_d;
      busy_q      <= busy_d;
      sync_q      <= sync_d;
`ifdef ANTON_NEOPIXEL_32BIT_EN
      mode32_q    <= mode32_d;
`endif
    end
  end

  assign pixelIndex     = pixel_idx_q;
  assign neoData        = neo_q;
  assign state          = busy_q;
  assign stream_sync_of = sync_q;

endmodule

// File: tb/tb_anton_neopixel_stream.sv
module tb_anton_neopixel_stream;

  localparam int END  = 7;
  localparam int T0H  = 8;
  localparam int T1H  = 16;
  localparam int TBIT = 25;
  localparam int RST  = 1000;
`ifdef ANTON_NEOPIXEL_32BIT_EN
  localparam bit M32_EN = 1'b1;
`else
  localparam bit M32_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  pidx;
  logic [7:0]  pbyte;
  logic [12:0] rmax;
  logic        lim, run, m32;
  logic        neo, st, sync;
  logic [7:0]  mem [8];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;
  assign pbyte = mem[pidx];

  anton_neopixel_stream #(
    .BUFFER_END(END), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .RESET_CYCLES(RST)
  ) dut (
    .busClk(clk), .busReset(rst), .pixelIndex(pidx), .pixelByte(pbyte),
    .reg_max(rmax), .reg_ctrl_limit(lim), .reg_ctrl_run(run), .reg_ctrl_32bit(m32),
    .neoData(neo), .state(st), .stream_sync_of(sync)
  );

  // Captured frame (one entry per cycle, from the first bit cycle to sync).
  logic cap_data[$];
  logic cap_sync[$];
  logic cap_state[$];
  int   cap_idx[$];
  bit   cap_timeout;
  logic pre_data, pre_state;
  // Reference model outputs.
  int   exp_idx[$];
  logic exp_wave[$];

  // Bytes a frame should send, straight from the end-index and padding rules.
  task automatic model_indices(input bit l, input int rm, input bit m);
    int last;
    exp_idx.delete();
    last = (l && rm < END) ? rm : END;
    for (int i = 0; i <= last; i++) begin
      if (!(M32_EN && m && (i % 4) == 3)) exp_idx.push_back(i);
    end
  endtask

  task automatic model_wave();
    exp_wave.delete();
    foreach (exp_idx[k]) begin
      for (int b = 7; b >= 0; b--) begin
        int hi;
        hi = mem[exp_idx[k]][b] ? T1H : T0H;
        for (int c = 0; c < TBIT; c++) exp_wave.push_back(c < hi);
      end
    end
    for (int c = 0; c < RST; c++) exp_wave.push_back(1'b0);
  endtask

  // Starts a frame and records it. Optional mid-frame action at sample act_at:
  // 1 = buffer write mem[a]=v, 2 = reg_max=v with limit=a, 3 = drop run.
  task automatic do_frame(input bit hold, input int act_at, input int kind,
                          input int a, input int v);
    bit done = 0;
    cap_data.delete(); cap_sync.delete(); cap_state.delete(); cap_idx.delete();
    @(negedge clk); run = 1'b1;
    @(negedge clk); pre_data = neo; pre_state = st;
    if (!hold) run = 1'b0;
    for (int j = 0; j < 6000 && !done; j++) begin
      if (j == act_at) begin
        if (kind == 1) mem[a] = 8'(v);
        else if (kind == 2) begin rmax = 13'(v); lim = a[0]; end
        else if (kind == 3) run = 1'b0;
      end
      @(negedge clk);
      cap_data.push_back(neo); cap_sync.push_back(sync);
      cap_state.push_back(st); cap_idx.push_back(int'(pidx));
      if (sync) done = 1;
    end
    cap_timeout = !done;
  endtask

  // Number of disagreements between the captured frame and the model.
  function automatic int frame_errors();
    int e = 0;
    int nb = exp_idx.size() * 8 * TBIT;
    int n;
    int q[$];
    if (cap_timeout) e++;
    if (cap_data.size() != exp_wave.size()) e++;
    n = (cap_data.size() < exp_wave.size()) ? cap_data.size() : exp_wave.size();
    for (int i = 0; i < n; i++) begin
      if (cap_data[i] !== exp_wave[i]) e++;
      if (cap_state[i] !== 1'b1) e++;
      if (cap_sync[i] !== (i == exp_wave.size() - 1)) e++;
    end
    for (int i = 0; i < nb && i < cap_idx.size(); i++) begin
      if (q.size() == 0 || q[$] != cap_idx[i]) q.push_back(cap_idx[i]);
    end
    if (q.size() != exp_idx.size()) e++;
    else foreach (q[k]) if (q[k] != exp_idx[k]) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; lim = 1'b0; m32 = 1'b0; rmax = '0;
    #1;
    n_checks++;
    if ({neo, st, sync} !== 3'b000) begin
      n_fails++; $display("FAIL reset_outputs: got %b required 000", {neo, st, sync});
    end
    n_checks++;
    if (pidx !== 3'd0) begin
      n_fails++; $display("FAIL reset_index: got %0d required 0", pidx);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({neo, st, sync} !== 3'b000) begin
      n_fails++; $display("FAIL idle_after_reset: got %b required 000", {neo, st, sync});
    end
  endtask

  task automatic test_single_byte();
    int exp_w[8] = '{16, 8, 16, 8, 8, 16, 8, 16};
    mem[0] = 8'hA5; lim = 1'b1; rmax = 13'd0; m32 = 1'b0;
    do_frame(0, -1, 0, 0, 0);
    model_indices(1, 0, 0); model_wave();
    n_checks++;
    if (pre_data !== 1'b0 || cap_data.size() == 0 || cap_data[0] !== 1'b1) begin
      n_fails++; $display("FAIL single_first_rise: pre=%b first=%b required 0,1",
                          pre_data, (cap_data.size() > 0) ? cap_data[0] : 1'bx);
    end
    for (int s = 0; s < 8; s++) begin
      int w = 0;
      for (int c = 0; c < TBIT && s * TBIT + c < cap_data.size(); c++)
        w += int'(cap_data[s * TBIT + c]);
      n_checks++;
      if (w != exp_w[s]) begin
        n_fails++; $display("FAIL single_width[%0d]: got %0d required %0d", s, w, exp_w[s]);
      end
    end
    n_checks++;
    if (frame_errors() != 0) begin
      n_fails++; $display("FAIL single_frame: errors=%0d required 0 (len %0d vs %0d)",
                          frame_errors(), cap_data.size(), exp_wave.size());
    end
    @(negedge clk);
    n_checks++;
    if (st !== 1'b0) begin
      n_fails++; $display("FAIL single_state_after: got %b required 0", st);
    end
  endtask

  task automatic test_full_buffer();
    foreach (mem[i]) mem[i] = 8'($urandom);
    lim = 1'b0; m32 = 1'b0;
    do_frame(0, -1, 0, 0, 0);
    model_indices(0, 0, 0); model_wave();
    n_checks++;
    if (cap_data.size() != 2600) begin
      n_fails++; $display("FAIL full_length: got %0d required 2600", cap_data.size());
    end
    n_checks++;
    if (frame_errors() != 0) begin
      n_fails++; $display("FAIL full_frame: errors=%0d required 0", frame_errors());
    end
  endtask

  task automatic test_32bit_skip();
    int slots;
    foreach (mem[i]) mem[i] = 8'($urandom);
    lim = 1'b1; rmax = 13'd7; m32 = 1'b1;
    do_frame(0, -1, 0, 0, 0);
    model_indices(1, 7, 1); model_wave();
    slots = (cap_data.size() - RST) / TBIT;
    n_checks++;
    if (slots != (M32_EN ? 48 : 64)) begin
      n_fails++; $display("FAIL skip_slots: got %0d required %0d", slots, M32_EN ? 48 : 64);
    end
    n_checks++;
    if (frame_errors() != 0) begin
      n_fails++; $display("FAIL skip_frame: errors=%0d required 0", frame_errors());
    end
    m32 = 1'b0;
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 6; it++) begin
      bit l, m;
      int rm;
      foreach (mem[i]) mem[i] = 8'($urandom);
      l = 1'($urandom); m = 1'($urandom);
      rm = ($urandom_range(0, 3) == 0) ? 8191 : int'($urandom_range(0, 9));
      lim = l; m32 = m; rmax = 13'(rm);
      do_frame(0, -1, 0, 0, 0);
      model_indices(l, rm, m); model_wave();
      n_checks++;
      if (frame_errors() != 0) begin
        n_fails++; $display("FAIL random_frame[%0d] l=%0d m=%0d max=%0d: errors=%0d required 0",
                            it, l, m, rm, frame_errors());
      end
    end
    m32 = 1'b0;
  endtask

  task automatic test_live_write();
    int v;
    foreach (mem[i]) mem[i] = 8'($urandom);
    v = int'(~mem[5]) & 8'hff;
    lim = 1'b0;
    do_frame(0, 300, 1, 5, v);
    model_indices(0, 0, 0); model_wave();
    n_checks++;
    if (frame_errors() != 0) begin
      n_fails++; $display("FAIL live_write: errors=%0d required 0", frame_errors());
    end
  endtask

  task automatic test_clamp_shadow();
    lim = 1'b1; rmax = 13'd8191;
    do_frame(0, -1, 0, 0, 0);
    n_checks++;
    if (cap_data.size() != 8 * 8 * TBIT + RST) begin
      n_fails++; $display("FAIL clamp_length: got %0d required %0d",
                          cap_data.size(), 8 * 8 * TBIT + RST);
    end
    rmax = 13'd2;
    do_frame(0, 100, 2, 1, 7);
    model_indices(1, 2, 0); model_wave();
    n_checks++;
    if (frame_errors() != 0) begin
      n_fails++; $display("FAIL shadow_max: errors=%0d required 0 (len %0d vs %0d)",
                          frame_errors(), cap_data.size(), exp_wave.size());
    end
  endtask

  task automatic test_loop();
    int k = 0;
    int len = 0;
    bit seen = 0;
    bit busy_seen = 0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    lim = 1'b0; m32 = 1'b0;
    do_frame(1, -1, 0, 0, 0);
    model_indices(0, 0, 0); model_wave();
    n_checks++;
    if (frame_errors() != 0) begin
      n_fails++; $display("FAIL loop_frame1: errors=%0d required 0", frame_errors());
    end
    while (k < 10 && neo !== 1'b1) begin @(negedge clk); k++; end
    n_checks++;
    if (k != 2) begin
      n_fails++; $display("FAIL loop_restart_gap: got %0d cycles required 2", k);
    end
    len = 1;
    while (len < 4000 && !seen) begin
      if (len == 100) run = 1'b0;
      @(negedge clk); len++;
      if (sync) seen = 1;
    end
    n_checks++;
    if (!seen || len != 2600) begin
      n_fails++; $display("FAIL loop_frame2_length: got %0d (sync %0d) required 2600", len, seen);
    end
    repeat (60) begin
      @(negedge clk);
      if (st || neo) busy_seen = 1;
    end
    n_checks++;
    if (busy_seen) begin
      n_fails++; $display("FAIL loop_stop: restarted after run dropped, required idle");
    end
  endtask

  task automatic test_reset_midframe();
    bit bad = 0;
    lim = 1'b0;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    repeat (506) @(negedge clk);
    n_checks++;
    if (st !== 1'b1 || pidx !== 3'd2) begin
      n_fails++; $display("FAIL midframe_position: state=%b idx=%0d required 1,2", st, pidx);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({neo, st, sync} !== 3'b000 || pidx !== 3'd0) begin
      n_fails++; $display("FAIL midframe_reset: got %b idx=%0d required 000 idx=0",
                          {neo, st, sync}, pidx);
    end
    @(negedge clk); rst = 1'b0;
    repeat (1200) begin
      @(negedge clk);
      if (sync || st || neo) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fails++; $display("FAIL midframe_no_sync: activity after reset, required none");
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_full_buffer();
    test_32bit_skip();
    test_random_frames();
    test_live_write();
    test_clamp_shadow();
    test_loop();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
